// File: rtl/pll_reset_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl_if
// Signal bundle between the PLL reset/lock sequencer and its surroundings.
//   i_pll_locked  : PLL locked flag, asynchronous to the reference clock
//   i_force_reset : one-cycle synchronous request to restart the sequence
//   o_pll_rst     : active-high PLL reset
//   o_sys_nrst    : active-low downstream system reset
//   o_ready       : high while the clock domain is up (RUN)
//   o_fail        : high when lock retries are exhausted (FAIL)
//   o_retry_cnt   : lock timeouts since the last RUN or force
//   o_lost_cnt    : lock losses seen in RUN, saturating
// master : the sequencer side.  slave : the PLL / system side.
// -----------------------------------------------------------------------------
interface pll_reset_ctrl_if;
    logic       i_pll_locked;
    logic       i_force_reset;
    logic       o_pll_rst;
    logic       o_sys_nrst;
    logic       o_ready;
    logic       o_fail;
    logic [3:0] o_retry_cnt;
    logic [7:0] o_lost_cnt;

    modport master (
        input  i_pll_locked,
        input  i_force_reset,
        output o_pll_rst,
        output o_sys_nrst,
        output o_ready,
        output o_fail,
        output o_retry_cnt,
        output o_lost_cnt
    );

    modport slave (
        output i_pll_locked,
        output i_force_reset,
        input  o_pll_rst,
        input  o_sys_nrst,
        input  o_ready,
        input  o_fail,
        input  o_retry_cnt,
        input  o_lost_cnt
    );
endinterface

// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
// Reset and lock sequencer for the system PLL. Runs on the free-running
// reference clock. Pulses the PLL reset, waits for a debounced lock with a
// timeout and bounded retries, then releases the downstream system reset.
// Any loss of lock in RUN pulls the system reset and restarts the sequence.
// Ports:
//   i_clk  : reference clock, free-running
//   i_nrst : asynchronous active-low reset
//   bus    : pll_reset_ctrl_if.master (lock/force inputs, reset/status outputs)
// All outputs are registered and decoded from the state being entered, so
// they always describe the current state with no extra cycle of delay.
// -----------------------------------------------------------------------------
module pll_reset_ctrl #(
    parameter int RST_HOLD     = 8,
    parameter int LOCK_TIMEOUT = 100,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    pll_reset_ctrl_if.master        bus
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [15:0] RST_HOLD_LAST     = 16'(RST_HOLD - 1);
    localparam logic [15:0] LOCK_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] LOCK_STABLE_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [3:0]  MAX_RETRY_V       = 4'(MAX_RETRY);

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nx_s;
    logic [3:0]  retry_r;
    logic [3:0]  retry_nx_s;
    logic [3:0]  retry_inc_s;
    logic [7:0]  lost_r;
    logic [7:0]  lost_nx_s;
    logic        lk_meta_r;
    logic        lk_r;
    logic        pll_rst_r;
    logic        sys_nrst_r;
    logic        ready_r;
    logic        fail_r;

    // Two-flop synchroniser bringing the asynchronous PLL lock into i_clk.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            lk_meta_r <= 1'b0;
            lk_r      <= 1'b0;
        end else begin
            lk_meta_r <= bus.i_pll_locked;
            lk_r      <= lk_meta_r;
        end
    end

    // Next-state, retry and lock-loss bookkeeping; force overrides everything.
    always_comb begin
        state_nx_s  = state_r;
        retry_nx_s  = retry_r;
        lost_nx_s   = lost_r;
        retry_inc_s = retry_r + 4'd1;
        if (bus.i_force_reset) begin
            state_nx_s = ST_RESET_PLL;
            retry_nx_s = 4'd0;
        end else begin
            case (state_r)
                ST_RESET_PLL: begin
                    if (cnt_r == RST_HOLD_LAST) begin
                        state_nx_s = ST_WAIT_LOCK;
                    end else begin
                        state_nx_s = ST_RESET_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_r) begin
                        state_nx_s = ST_STABLE;
                    end else if (cnt_r == LOCK_TIMEOUT_LAST) begin
                        retry_nx_s = retry_inc_s;
                        if (retry_inc_s == MAX_RETRY_V) begin
                            state_nx_s = ST_FAIL;
                        end else begin
                            state_nx_s = ST_RESET_PLL;
                        end
                    end else begin
                        state_nx_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    // A single low cycle of the synchronised lock restarts
                    // the wait window without counting as a retry.
                    if (!lk_r) begin
                        state_nx_s = ST_WAIT_LOCK;
                    end else if (cnt_r == LOCK_STABLE_LAST) begin
                        state_nx_s = ST_RUN;
                        retry_nx_s = 4'd0;
                    end else begin
                        state_nx_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    if (!lk_r) begin
                        state_nx_s = ST_RESET_PLL;
                        if (lost_r != 8'd255) begin
                            lost_nx_s = lost_r + 8'd1;
                        end else begin
                            lost_nx_s = lost_r;
                        end
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_nx_s = ST_FAIL;
                end
                default: begin
                    state_nx_s = ST_RESET_PLL;
                end
            endcase
        end
    end

    // Shared timer: clears on any state entry (including a forced re-entry
    // of RESET_PLL) and only runs in the timed states, so it never wraps.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (bus.i_force_reset || (state_nx_s != state_r)) begin
            cnt_nx_s = 16'd0;
        end else if ((state_r == ST_RESET_PLL) || (state_r == ST_WAIT_LOCK) ||
                     (state_r == ST_STABLE)) begin
            cnt_nx_s = cnt_r + 16'd1;
        end else begin
            cnt_nx_s = 16'd0;
        end
    end

    // Sequencer state, counters and output registers decoded from next state.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r    <= ST_RESET_PLL;
            cnt_r      <= 16'd0;
            retry_r    <= 4'd0;
            lost_r     <= 8'd0;
            pll_rst_r  <= 1'b1;
            sys_nrst_r <= 1'b0;
            ready_r    <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            retry_r    <= retry_nx_s;
            lost_r     <= lost_nx_s;
            pll_rst_r  <= (state_nx_s == ST_RESET_PLL) || (state_nx_s == ST_FAIL);
            sys_nrst_r <= (state_nx_s == ST_RUN);
            ready_r    <= (state_nx_s == ST_RUN);
            fail_r     <= (state_nx_s == ST_FAIL);
        end
    end

    assign bus.o_pll_rst   = pll_rst_r;
    assign bus.o_sys_nrst  = sys_nrst_r;
    assign bus.o_ready     = ready_r;
    assign bus.o_fail      = fail_r;
    assign bus.o_retry_cnt = retry_r;
    assign bus.o_lost_cnt  = lost_r;

endmodule
